// File: rtl/apb_bridge_mux.sv
// Host-to-APB4 bridge with NSLV-way address decode, wait-state support and error return.
// Optional ACCESS watchdog enabled by defining APB_BRIDGE_TIMEOUT_EN.
module apb_bridge_mux #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    NSLV        = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h4000_0000,
  parameter int                    SLV_SHIFT   = 12,
  parameter int                    TIMEOUT_CYC = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [3:0]            HBE,
  input  logic [31:0]           HWDATA,
  output logic [31:0]           HRDATA,
  output logic                  HREADY,
  output logic                  HRESP,
  output logic [NSLV-1:0]       PSEL,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [3:0]            PSTRB,
  output logic [31:0]           PWDATA,
  input  logic [NSLV*32-1:0]    PRDATA,
  input  logic [NSLV-1:0]       PREADY,
  input  logic [NSLV-1:0]       PSLVERR
);

  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NSLV-1:0]       psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [3:0]            pstrb_q, pstrb_d;
  logic [31:0]           pwdata_q, pwdata_d;
  logic [31:0]           hrdata_q, hrdata_d;
  logic                  hready_q, hready_d;
  logic                  hresp_q, hresp_d;
`ifdef APB_BRIDGE_TIMEOUT_EN
  logic [15:0]           cnt_q, cnt_d;
`endif

  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] slot;
  logic                  hit;
  logic                  sel_ready;
  logic                  sel_err;
  logic [31:0]           sel_rdata;

  // Slot index is compared at full width so addresses far above the window still miss.
  assign off  = HADDR - BASE_ADDR;
  assign slot = off >> SLV_SHIFT;
  assign hit  = (HADDR >= BASE_ADDR) && (slot < ADDR_WIDTH'(NSLV));

  assign sel_ready = PREADY[idx_q];
  assign sel_err   = PSLVERR[idx_q];
  assign sel_rdata = PRDATA[{idx_q, 5'd0} +: 32];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pstrb_d   = pstrb_q;
    pwdata_d  = pwdata_q;
    hrdata_d  = hrdata_q;
    hready_d  = 1'b0;
    hresp_d   = hresp_q;
`ifdef APB_BRIDGE_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (HSEL) begin
          if (hit) begin
            idx_d             = slot[IW-1:0];
            psel_d            = '0;
            psel_d[slot[IW-1:0]] = 1'b1;
            penable_d         = 1'b0;
            paddr_d           = HADDR;
            pwrite_d          = HWRITE;
            pstrb_d           = HWRITE ? HBE : 4'h0;
            pwdata_d          = HWDATA;
            state_d           = S_SETUP;
          end else begin
            hrdata_d = 32'h0;
            hresp_d  = 1'b1;
            hready_d = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
`ifdef APB_BRIDGE_TIMEOUT_EN
        cnt_d     = 16'h0;
`endif
      end
      S_ACCESS: begin
        if (sel_ready) begin
          hrdata_d  = pwrite_q ? 32'h0 : sel_rdata;
          hresp_d   = sel_err;
          hready_d  = 1'b1;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = S_DONE;
        end
`ifdef APB_BRIDGE_TIMEOUT_EN
        // A late PREADY in the final watchdog cycle still completes normally.
        else if (cnt_q == 16'(TIMEOUT_CYC - 1)) begin
          hrdata_d  = 32'h0;
          hresp_d   = 1'b1;
          hready_d  = 1'b1;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'h1;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pstrb_q   <= 4'h0;
      pwdata_q  <= 32'h0;
      hrdata_q  <= 32'h0;
      hready_q  <= 1'b0;
      hresp_q   <= 1'b0;
`ifdef APB_BRIDGE_TIMEOUT_EN
      cnt_q     <= 16'h0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pstrb_q   <= pstrb_d;
      pwdata_q  <= pwdata_d;
      hrdata_q  <= hrdata_d;
      hready_q  <= hready_d;
      hresp_q   <= hresp_d;
`ifdef APB_BRIDGE_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PADDR   = paddr_q;
  assign PWRITE  = pwrite_q;
  assign PSTRB   = pstrb_q;
  assign PWDATA  = pwdata_q;
  assign HRDATA  = hrdata_q;
  assign HREADY  = hready_q;
  assign HRESP   = hresp_q;

endmodule

// File: tb/tb_apb_bridge_mux.sv
// Directed bench for apb_bridge_mux: scoreboarded host transfers against a small APB slave model.
module tb_apb_bridge_mux;

  logic         PCLK = 1'b0;
  logic         PRESETn = 1'b0;
  logic         HSEL = 1'b0;
  logic [31:0]  HADDR = '0;
  logic         HWRITE = 1'b0;
  logic [3:0]   HBE = '0;
  logic [31:0]  HWDATA = '0;
  logic [31:0]  HRDATA;
  logic         HREADY;
  logic         HRESP;
  logic [3:0]   PSEL;
  logic         PENABLE;
  logic [31:0]  PADDR;
  logic         PWRITE;
  logic [3:0]   PSTRB;
  logic [31:0]  PWDATA;
  logic [127:0] PRDATA;
  logic [3:0]   PREADY;
  logic [3:0]   PSLVERR;

  always #5 PCLK = ~PCLK;

  apb_bridge_mux dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HBE(HBE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PSTRB(PSTRB),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Slave model: each slave becomes ready after waits[i] ACCESS cycles unless stuck.
  int          waits [4];
  logic [3:0]  stuck = '0;
  logic [3:0]  errv = '0;
  logic [31:0] rdv [4];
  int          acc_cnt;

  initial begin
    waits = '{0, 0, 0, 0};
    rdv   = '{32'h1111_0000, 32'h2222_1111, 32'hCAFE_F00D, 32'h4444_3333};
  end

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)     acc_cnt <= 0;
    else if (PENABLE) acc_cnt <= acc_cnt + 1;
    else              acc_cnt <= 0;
  end

  always_comb begin
    PREADY = '0;
    for (int i = 0; i < 4; i++) PREADY[i] = !stuck[i] && (acc_cnt >= waits[i]);
  end
  assign PSLVERR = errv;
  assign PRDATA  = {rdv[3], rdv[2], rdv[1], rdv[0]};

  typedef struct {
    logic [31:0] rd;
    logic        resp;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Called right after a rising edge with the bridge in IDLE; leaves at the same point.
  task automatic do_xfer(input string tag, input logic [31:0] a, input logic w, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_resp,
                         input int exp_lat, input logic [3:0] exp_psel, input logic [3:0] exp_pstrb,
                         input int exp_pen);
    exp_t        e;
    exp_t        got;
    int          cyc;
    int          pen;
    logic        done;
    logic [3:0]  psel_seen, pstrb_seen;
    logic        setup_pen, pwrite_seen;
    logic [31:0] paddr_seen, pwdata_seen;
    HSEL = 1'b1; HADDR = a; HWRITE = w; HBE = be; HWDATA = wd;
    e.rd = exp_rd; e.resp = exp_resp; e.lat = exp_lat;
    sb.push_back(e);
    cyc = 0; pen = 0; done = 1'b0;
    psel_seen = '0; pstrb_seen = '0; setup_pen = 1'b0; pwrite_seen = 1'b0;
    paddr_seen = '0; pwdata_seen = '0;
    while (!done && cyc < 2000) begin
      @(posedge PCLK); #1;
      cyc++;
      if (PSEL != 4'h0 && psel_seen == 4'h0) begin
        psel_seen = PSEL; pstrb_seen = PSTRB; setup_pen = PENABLE;
        paddr_seen = PADDR; pwdata_seen = PWDATA; pwrite_seen = PWRITE;
      end
      if (PENABLE) pen++;
      if (HREADY) done = 1'b1;
    end
    if (!done) chk({tag, "_hready_timeout"}, 64'(done), 64'd1);
    got = sb.pop_front();
    chk({tag, "_latency"}, 64'(cyc), 64'(got.lat));
    chk({tag, "_hrdata"}, 64'(HRDATA), 64'(got.rd));
    chk({tag, "_hresp"}, 64'(HRESP), 64'(got.resp));
    chk({tag, "_psel"}, 64'(psel_seen), 64'(exp_psel));
    chk({tag, "_penable_cycles"}, 64'(pen), 64'(exp_pen));
    if (exp_psel != 4'h0) begin
      chk({tag, "_setup_penable"}, 64'(setup_pen), 64'd0);
      chk({tag, "_pstrb"}, 64'(pstrb_seen), 64'(exp_pstrb));
      chk({tag, "_paddr"}, 64'(paddr_seen), 64'(a));
      chk({tag, "_pwrite"}, 64'(pwrite_seen), 64'(w));
      if (w) chk({tag, "_pwdata"}, 64'(pwdata_seen), 64'(wd));
    end
    $display("xfer %s addr=0x%08h wr=%0d lat=%0d hrdata=0x%08h hresp=%0d psel=%b",
             tag, a, w, cyc, HRDATA, HRESP, psel_seen);
    @(posedge PCLK); #1;
    chk({tag, "_hready_pulse"}, 64'(HREADY), 64'd0);
    chk({tag, "_hrdata_hold"}, 64'(HRDATA), 64'(got.rd));
    HSEL = 1'b0;
  endtask

  initial begin
    int hr;
    #12;
    chk("rst_host", {31'h0, HRDATA, HREADY, HRESP}, 64'd0);
    chk("rst_apb_ctl", 64'({PSEL, PENABLE, PWRITE, PSTRB}), 64'd0);
    chk("rst_paddr", 64'(PADDR), 64'd0);
    chk("rst_pwdata", 64'(PWDATA), 64'd0);
    #10 PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // Non-selected slaves flag errors; only slave0 is observed.
    errv = 4'b1110;
    do_xfer("wr_s0", 32'h4000_0010, 1'b1, 4'hF, 32'hA5A5_1234, 32'h0, 1'b0, 3, 4'b0001, 4'hF, 1);
    errv = 4'b0000;
    waits[2] = 3;
    do_xfer("rd_s2_wait3", 32'h4000_2004, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b0, 6, 4'b0100, 4'h0, 4);
    waits[2] = 0;
    do_xfer("miss_idx4", 32'h4000_4000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1, 4'b0000, 4'h0, 0);
    do_xfer("miss_below", 32'h3FFF_FFFC, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1, 4'b0000, 4'h0, 0);
    errv = 4'b0010;
    do_xfer("wr_s1_slverr", 32'h4000_1000, 1'b1, 4'h3, 32'h0BAD_BEEF, 32'h0, 1'b1, 3, 4'b0010, 4'h3, 1);
    errv = 4'b0000;
    do_xfer("rd_s1_b2b", 32'h4000_1008, 1'b0, 4'h0, 32'h0, 32'h2222_1111, 1'b0, 3, 4'b0010, 4'h0, 1);

    stuck[3] = 1'b1;
`ifdef APB_BRIDGE_TIMEOUT_EN
    do_xfer("rd_s3_timeout", 32'h4000_3000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 258, 4'b1000, 4'h0, 256);
    HSEL = 1'b1; HADDR = 32'h4000_3000; HWRITE = 1'b0;
    hr = 0;
    repeat (5) begin
      @(posedge PCLK); #1;
      if (HREADY) hr++;
    end
    chk("stuck_short_no_hready", 64'(hr), 64'd0);
`else
    HSEL = 1'b1; HADDR = 32'h4000_3000; HWRITE = 1'b0; HBE = 4'h0;
    hr = 0;
    repeat (1000) begin
      @(posedge PCLK); #1;
      if (HREADY) hr++;
    end
    chk("stuck_no_hready", 64'(hr), 64'd0);
    chk("stuck_still_access", 64'({PSEL, PENABLE}), 64'(5'b10001));
    $display("xfer stuck_s3 addr=0x40003000 still waiting after 1000 cycles psel=%b", PSEL);
`endif

    // Asynchronous reset mid-ACCESS, checked before any clock edge.
    #2 PRESETn = 1'b0;
    #1;
    chk("async_rst_ctl", 64'({PSEL, PENABLE, HREADY}), 64'd0);
    HSEL = 1'b0;
    stuck[3] = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    chk("post_rst_idle", 64'({PSEL, PENABLE, HREADY}), 64'd0);
    do_xfer("rd_s3_post_rst", 32'h4000_3010, 1'b0, 4'h0, 32'h0, 32'h4444_3333, 1'b0, 3, 4'b1000, 4'h0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
